// File: rtl/uart_fb_loader_pkg.sv
// Shared framebuffer constants: loader FSM state encoding, a constant-safe
// clog2 width helper, and the byte bit-reversal used on the write path.
// The LCD scan-out block imports the same package.
package uart_fb_loader_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,  // x=y=0, no frame in progress
    ST_STREAM = 1'b1   // frame partially received
  } fb_state_e;

  // ceil(log2(v)), never less than 1 so a 1-entry range still gets a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // Swap MSB/LSB order: the panel's column bytes are wired top-bit-first.
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/uart_fb_loader_pulse_stretch.sv
// pulse_stretch: retriggerable pulse stretcher.
//   clk   - system clock
//   reset - asynchronous active-high reset
//   trig  - restart the stretch window
//   out   - high for LEN cycles after the most recent trig, starting the
//           cycle after trig
module pulse_stretch
  import uart_fb_loader_pkg::*;
#(
  parameter int LEN = 4800000
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  output logic out
);

  localparam int CW = clog2(LEN + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (trig)         cnt <= CW'(LEN);
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign out = (cnt != '0);

endmodule

// File: rtl/uart_fb_loader.sv
// uart_fb_loader: turns a stream of received UART bytes into framebuffer
// write-port transactions, column-major (y inner, x outer). A partial frame
// is abandoned after TIMEOUT idle cycles so the host can resync by simply
// pausing. The RAM itself lives outside; only the write port comes from here.
//   clk, reset          - clock, asynchronous active-high reset
//   rx_data, rx_strobe  - received byte and its one-cycle valid
//   wr_en/wr_x/wr_y/wr_data - one-cycle registered write (1-cycle latency)
//   frame_done          - pulses with the write of the last byte of a frame
//   resync              - pulses when a partial frame is dropped on timeout
//   active              - stretched activity indicator (LED)
module uart_fb_loader
  import uart_fb_loader_pkg::*;
#(
  parameter int COLS        = 240,
  parameter int ROW_BYTES   = 8,
  parameter int BIT_REVERSE = 1,
  parameter int TIMEOUT     = 48000,
  parameter int ACT_CYCLES  = 4800000,
  parameter int XW          = clog2(COLS),
  parameter int YW          = clog2(ROW_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_strobe,
  output logic          wr_en,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [7:0]    wr_data,
  output logic          frame_done,
  output logic          resync,
  output logic          active
);

  localparam int CW = clog2(TIMEOUT + 1);

  fb_state_e     state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          wr_en_d, done_d, resync_d;
  logic          last_x, last_y;
  logic [7:0]    data_fmt;

  assign last_y   = (y_q == YW'(ROW_BYTES - 1));
  assign last_x   = (x_q == XW'(COLS - 1));
  assign data_fmt = (BIT_REVERSE != 0) ? bit_rev8(rx_data) : rx_data;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state / address / idle-counter logic. A strobe always takes
  // priority over the timeout check, so a byte arriving on the exact
  // timeout cycle is accepted at the current address.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    idle_d   = idle_q;
    wr_en_d  = 1'b0;
    done_d   = 1'b0;
    resync_d = 1'b0;
    if (rx_strobe) begin
      wr_en_d = 1'b1;
      idle_d  = '0;
      if (last_y) begin
        y_d = '0;
        if (last_x) begin
          x_d     = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          x_d     = x_q + 1'b1;
          state_d = ST_STREAM;
        end
      end else begin
        y_d     = y_q + 1'b1;
        state_d = ST_STREAM;
      end
    end else begin
      unique case (state_q)
        ST_STREAM: begin
          if (idle_q == CW'(TIMEOUT)) begin
            x_d      = '0;
            y_d      = '0;
            idle_d   = '0;
            resync_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        default: idle_d = '0;  // IDLE: counter parked at zero
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      idle_q     <= '0;
      wr_en      <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      resync     <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      idle_q     <= idle_d;
      wr_en      <= wr_en_d;
      frame_done <= done_d;
      resync     <= resync_d;
      if (rx_strobe) begin
        wr_x    <= x_q;
        wr_y    <= y_q;
        wr_data <= data_fmt;
      end
    end
  end

  pulse_stretch #(.LEN(ACT_CYCLES)) u_act (
    .clk   (clk),
    .reset (reset),
    .trig  (rx_strobe),
    .out   (active)
  );

endmodule

// File: tb/tb_uart_fb_loader.sv
// Directed bench for uart_fb_loader, small geometry (4x2, timeout 10,
// activity 20). A second instance with BIT_REVERSE=0 shares the inputs.
module tb_uart_fb_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_strobe = 1'b0;

  logic       wr_en, frame_done, resync, active;
  logic [1:0] wr_x;
  logic [0:0] wr_y;
  logic [7:0] wr_data;

  logic       wr_en_n, frame_done_n, resync_n, active_n;
  logic [1:0] wr_x_n;
  logic [0:0] wr_y_n;
  logic [7:0] wr_data_n;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_fb_loader #(.COLS(4), .ROW_BYTES(2), .BIT_REVERSE(1), .TIMEOUT(10), .ACT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .frame_done(frame_done), .resync(resync), .active(active)
  );

  uart_fb_loader #(.COLS(4), .ROW_BYTES(2), .BIT_REVERSE(0), .TIMEOUT(10), .ACT_CYCLES(20)) dut_n (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .wr_en(wr_en_n), .wr_x(wr_x_n), .wr_y(wr_y_n), .wr_data(wr_data_n),
    .frame_done(frame_done_n), .resync(resync_n), .active(active_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the write visible.
  task automatic send(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_done"},  frame_done, 0);
    chk({tag, "_resync"}, resync, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_x"},     wr_x, 0);
    chk({tag, "_y"},     wr_y, 0);
    chk({tag, "_data"},  wr_data, 0);
  endtask

  int         exp_x [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int         exp_y [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  logic [7:0] exp_d [8] = '{8'h80, 8'h40, 8'hC0, 8'h20, 8'hA0, 8'h60, 8'hE0, 8'h10};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("rel_wr_en", wr_en, 0);

    // Full frame, back-to-back strobes
    rx_strobe = 1'b1;
    rx_data   = 8'h01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_wr_en", wr_en, 1);
      chk("t1_x",     wr_x, exp_x[i]);
      chk("t1_y",     wr_y, exp_y[i]);
      chk("t1_data",  wr_data, exp_d[i]);
      chk("t1_done",  frame_done, 32'(i == 7));
      if (i < 7) rx_data = 8'(i + 2);
      else       rx_strobe = 1'b0;
    end
    @(negedge clk);
    chk("t1_wr_end",   wr_en, 0);
    chk("t1_done_end", frame_done, 0);

    // Timeout: three bytes, then 12 idle cycles
    send(8'h11);
    send(8'h22);
    send(8'h33);
    chk("t2_x3", wr_x, 1);
    chk("t2_y3", wr_y, 0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk("t2_resync", resync, 32'(k == 11));
      chk("t2_nowr",   wr_en, 0);
    end
    send(8'h44);
    chk("t2_wr_en",  wr_en, 1);
    chk("t2_x",      wr_x, 0);
    chk("t2_y",      wr_y, 0);
    chk("t2_done",   frame_done, 0);
    chk("t2_resync_after", resync, 0);

    // Strobe on the exact timeout cycle wins
    send(8'h55);
    send(8'h66);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t3_resync_wait", resync, 0);
    end
    send(8'h77);
    chk("t3_wr_en",  wr_en, 1);
    chk("t3_x",      wr_x, 1);
    chk("t3_y",      wr_y, 1);
    chk("t3_resync", resync, 0);
    @(negedge clk);
    chk("t3_resync_next", resync, 0);
    chk("t3_wr_next",     wr_en, 0);

    // Finish this frame, then reset mid-frame after five bytes
    for (int i = 0; i < 4; i++) begin
      send(8'(8'hA0 + i));
      chk("t4_fill_done", frame_done, 32'(i == 3));
    end
    for (int i = 0; i < 5; i++) send(8'(8'hB0 + i));
    chk("t4_pre_x", wr_x, 2);
    reset = 1'b1;
    #1;
    chk_zero("t4_async");
    @(negedge clk);
    chk_zero("t4_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t4_rel_wr",     wr_en, 0);
    chk("t4_rel_done",   frame_done, 0);
    chk("t4_rel_resync", resync, 0);
    send(8'hFF);
    chk("t4_wr_en", wr_en, 1);
    chk("t4_x",     wr_x, 0);
    chk("t4_y",     wr_y, 0);
    chk("t4_data",  wr_data, 8'hFF);

    // BIT_REVERSE=0 path and activity stretch
    send(8'h01);
    chk("t5_data_rev", wr_data, 8'h80);
    chk("t5_data_raw", wr_data_n, 8'h01);
    chk("t5_x_raw",    wr_x_n, 0);
    chk("t5_y_raw",    wr_y_n, 1);
    chk("t5_active0",  active, 1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("t5_active",   active, 32'(k < 20));
      chk("t5_active_n", active_n, 32'(k < 20));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fb_loader.md
UART_FB_LOADER -- requirements
Module: uart_fb_loader

Interface
REQ-001 Parameter COLS, 240, framebuffer columns (x range 0..COLS-1).
REQ-002 Parameter ROW_BYTES, 8, bytes per column (y range 0..ROW_BYTES-1); SHALL be a power of two, at least 2.
REQ-003 Parameter BIT_REVERSE, 1, 1 = store received byte MSB/LSB-swapped, 0 = store unchanged.
REQ-004 Parameter TIMEOUT, 48000, idle cycles in mid-frame before resync.
REQ-005 Parameter ACT_CYCLES, 4800000, activity output stretch length in cycles.
REQ-006 Derived widths: XW = clog2(COLS), YW = clog2(ROW_BYTES).
REQ-007 clk  input  1  single system clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 rx_data  input  8  received UART byte, valid only with rx_strobe.
REQ-010 rx_strobe  input  1  one-cycle pulse; byte accepted on this cycle.
REQ-011 wr_en  output  1  one-cycle framebuffer write enable.
REQ-012 wr_x  output  XW  column address of the write.
REQ-013 wr_y  output  YW  byte-lane index within the column (bits 8*wr_y +: 8).
REQ-014 wr_data  output  8  byte to store.
REQ-015 frame_done  output  1  one-cycle pulse, last byte of a frame written.
REQ-016 resync  output  1  one-cycle pulse, partial frame abandoned on timeout.
REQ-017 active  output  1  high while stretched activity is pending (LED drive).

Function
REQ-018 FSM states: IDLE (x=y=0, no frame in progress) and STREAM (frame partially received).
REQ-019 On rx_strobe, the block SHALL register one write: next cycle wr_en=1, wr_x/wr_y = current x/y, wr_data = rx_data (bit-reversed if BIT_REVERSE=1); latency exactly 1 cycle.
REQ-020 Address advance per accepted byte: y increments; at y=ROW_BYTES-1, y wraps to 0 and x increments.
REQ-021 At x=COLS-1, y=ROW_BYTES-1, the accepted byte SHALL complete the frame: x,y return to 0, state to IDLE, frame_done pulses in the same cycle as that byte's wr_en.
REQ-022 IDLE->STREAM on any accepted byte that does not complete a frame; STREAM->IDLE on frame completion or timeout.
REQ-023 Idle counter SHALL clear on every rx_strobe and increment each cycle in STREAM without a strobe.
REQ-024 When the idle counter reaches TIMEOUT in STREAM with no strobe that cycle: x,y clear, state IDLE, resync pulses next cycle, no write is issued.
REQ-025 A strobe in the cycle the counter reaches TIMEOUT SHALL win: the byte is accepted at the current address and no resync occurs.
REQ-026 In IDLE the idle counter SHALL hold at 0; resync never pulses from IDLE.
REQ-027 active SHALL go high the cycle after any rx_strobe and stay high ACT_CYCLES cycles after the most recent strobe (retriggerable).
REQ-028 wr_en, frame_done and resync SHALL each be high for exactly one cycle per event, never back-to-back from a single strobe.
REQ-029 Back-to-back strobes on consecutive cycles SHALL each produce one write at consecutive addresses.

Reset
REQ-030 Reset SHALL asynchronously force state IDLE, x=y=0, idle and activity counters 0, and all outputs 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; the first byte after release goes to x=0, y=0.
REQ-032 No write, frame_done or resync SHALL be issued in the cycle reset deasserts.

Structure
REQ-033 State encodings and the clog2 width helper SHALL live in the shared framebuffer constants include, reused by the LCD scan-out block.
REQ-034 The retriggerable stretcher SHALL be a sub-module named pulse_stretch (parameter LEN, ports clk, reset, trig, out).
REQ-035 The framebuffer RAM SHALL remain outside this block; only the write port is produced here.

Verification (COLS=4, ROW_BYTES=2, TIMEOUT=10, ACT_CYCLES=20)
REQ-036 Eight strobes, bytes 0x01..0x08 -> writes (x,y)=(0,0)..(3,1), wr_data 0x80,0x40,0xC0,0x20,0xA0,0x60,0xE0,0x10; frame_done with the eighth write only.
REQ-037 Three bytes then 12 idle cycles -> resync pulse once, 11 cycles after the third strobe; next byte written at (0,0), no frame_done.
REQ-038 Strobe exactly on the cycle the counter reaches 10 -> written at (1,1), no resync.
REQ-039 Reset asserted after five bytes, released, one byte 0xFF -> write at (0,0), all outputs 0 during reset.
REQ-040 BIT_REVERSE=0, byte 0x01 -> wr_data 0x01; active high 20 cycles after last strobe, then low.
